// File: rtl/fetch_sequencer.sv
// fetch_sequencer: control-side driver of the program counter.
// Starts a program at a requested address, decodes each fetched word for
// branch/halt, steers the PC through start/branch/taken/target, and reports
// run status (busy/done/err), run length and the halt address.
module fetch_sequencer #(
  parameter int instr_width = 9,
  parameter int reg_width   = 8,
  parameter int word_width  = 9,
  parameter int cnt_width   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   go,
  input  logic [instr_width-1:0] prog_addr,
  input  logic [instr_width-1:0] pc_in,
  input  logic [word_width-1:0]  instr,
  input  logic [word_width-1:0]  operand,
  input  logic                   flag_z,
  output logic                   start,
  output logic [instr_width-1:0] start_addr,
  output logic                   branch,
  output logic                   taken,
  output logic [reg_width-1:0]   target,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [cnt_width-1:0]   cycle_count,
  output logic [instr_width-1:0] halted_at
);

  // Sequencer states (IDLE -> LOAD -> RUN -> DONE -> LOAD ...)
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Opcode field (top four bits of the word) for the two conditional branches.
  localparam logic [3:0] OP_BRZ  = 4'b1110;
  localparam logic [3:0] OP_BRNZ = 4'b1101;

  localparam logic [word_width-1:0] HALT_WORD = '1;
  localparam logic [cnt_width-1:0]  CNT_MAX   = '1;
  localparam logic [cnt_width-1:0]  CNT_ONE   = cnt_width'(1);

  // Common width wide enough to compare the backward offset against the PC.
  localparam int CMP_W = ((instr_width > reg_width) ? instr_width : reg_width) + 1;

  logic [1:0]             r_state;
  logic [1:0]             w_next_state;
  logic [cnt_width-1:0]   r_cycle_count;
  logic [cnt_width-1:0]   w_next_count;
  logic [cnt_width-1:0]   w_count_inc;
  logic                   r_err;
  logic                   w_next_err;
  logic [instr_width-1:0] r_halted_at;
  logic [instr_width-1:0] w_next_halted_at;
  logic                   r_start;
  logic [instr_width-1:0] r_start_addr;
  logic [instr_width-1:0] w_next_start_addr;
  logic                   r_busy;
  logic                   r_done;

  logic                   w_run;
  logic                   w_is_halt;
  logic                   w_is_brz;
  logic                   w_is_brnz;
  logic                   w_is_branch;
  logic                   w_cond;
  logic                   w_underflow;
  logic [reg_width-1:0]   w_offset;

  // Operand bits above the offset field carry no meaning for this sequencer.
  logic                   w_operand_unused;
  assign w_operand_unused = ^operand[word_width-1:reg_width];

  // ---------------------------------------------------------------------------
  // Instruction decode (combinational, same cycle as instr)
  // ---------------------------------------------------------------------------
  assign w_run       = (r_state == S_RUN);
  assign w_is_halt   = (instr == HALT_WORD);
  assign w_is_brz    = !w_is_halt && (instr[word_width-1 -: 4] == OP_BRZ);
  assign w_is_brnz   = !w_is_halt && (instr[word_width-1 -: 4] == OP_BRNZ);
  assign w_is_branch = w_run && (w_is_brz || w_is_brnz);
  assign w_cond      = w_is_brz ? flag_z : ~flag_z;
  assign w_offset    = operand[reg_width-1:0];
  // A taken backward jump further than the current PC would wrap below zero.
  assign w_underflow = w_is_branch && w_cond && (CMP_W'(w_offset) > CMP_W'(pc_in));

  assign branch = w_is_branch;
  assign taken  = w_is_branch && w_cond && !w_underflow;
  assign target = w_is_branch ? w_offset : '0;

  // Saturating run-length increment.
  assign w_count_inc = (r_cycle_count == CNT_MAX) ? r_cycle_count : (r_cycle_count + CNT_ONE);

  // Next-state and next-status computation
  // NOTE: every signal assigned here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    w_next_state     = r_state;
    w_next_count     = r_cycle_count;
    w_next_err       = r_err;
    w_next_halted_at = r_halted_at;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (go) begin
          w_next_state     = S_LOAD;
          w_next_count     = '0;
          w_next_err       = 1'b0;
          w_next_halted_at = '0;
        end
      end
      S_LOAD: begin
        w_next_state = S_RUN;
      end
      S_RUN: begin
        w_next_count = w_count_inc;
        if (w_is_halt) begin
          w_next_halted_at = pc_in;
          w_next_state     = S_DONE;
        end else if (w_underflow || (w_count_inc == CNT_MAX)) begin
          w_next_err       = 1'b1;
          w_next_halted_at = pc_in;
          w_next_state     = S_DONE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // PC load value for the next cycle: program entry in LOAD, halt address in DONE
  always_comb begin
    w_next_start_addr = '0;
    if (w_next_state == S_LOAD) begin
      w_next_start_addr = prog_addr;
    end else if (w_next_state == S_DONE) begin
      w_next_start_addr = w_next_halted_at;
    end
  end

  // State, status and registered PC-control outputs
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cycle_count <= '0;
      r_err         <= 1'b0;
      r_halted_at   <= '0;
      r_start       <= 1'b0;
      r_start_addr  <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_cycle_count <= w_next_count;
      r_err         <= w_next_err;
      r_halted_at   <= w_next_halted_at;
      r_start       <= (w_next_state == S_LOAD) || (w_next_state == S_DONE);
      r_start_addr  <= w_next_start_addr;
      r_busy        <= (w_next_state == S_LOAD) || (w_next_state == S_RUN);
      r_done        <= (w_next_state == S_DONE);
    end
  end

  assign start       = r_start;
  assign start_addr  = r_start_addr;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;
  assign cycle_count = r_cycle_count;
  assign halted_at   = r_halted_at;

endmodule
